// File: rtl/seq_pkg.sv
// Shared constants, state encoding and target-address helper for the
// program sequencer.
package seq_pkg;
    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int SP_W        = $clog2(STACK_DEPTH + 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } seq_state_t;

    // Jump targets are 16-word aligned: the nibble from the IR selects the page.
    function automatic logic [ADDR_W-1:0] jmp_target(input logic [3:0] nib);
        return {nib, {(ADDR_W-4){1'b0}}};
    endfunction
endpackage

// File: rtl/seq_stack.sv
// Return-address LIFO for call/ret. sp counts filled entries (0..STACK_DEPTH).
// Only instantiated when SEQ_CALL_STACK_EN is defined.
module seq_stack
    import seq_pkg::*;
(
    input  logic              clk,
    input  logic              i_sync_reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_top
);
    localparam int              IDX_W   = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [SP_W-1:0]   r_sp;
    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];

    assign o_full  = (r_sp == SP_FULL);
    assign o_empty = (r_sp == '0);
    // Top entry is meaningless when empty; the caller checks o_empty first.
    assign o_top   = r_mem[IDX_W'(r_sp - SP_ONE)];

    // Stack pointer: reset clears it, caller guarantees no push when full / pop when empty.
    always_ff @(posedge clk) begin
        if (i_sync_reset)
            r_sp <= '0;
        else if (i_push)
            r_sp <= r_sp + SP_ONE;
        else if (i_pop)
            r_sp <= r_sp - SP_ONE;
    end

    // Storage has no reset; stale entries are unreachable once sp is cleared.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[IDX_W'(r_sp)] <= i_push_data;
    end
endmodule

// File: rtl/program_sequencer_ctrl.sv
// Program sequencer: picks the next program-memory address each cycle
// (reset / halt / jmp / jmp_nz / call / ret / increment) and runs a
// RUN-HALT-STEP debug FSM. Optional call stack under SEQ_CALL_STACK_EN;
// without it call/ret are ignored and the error flags read 0.
module program_sequencer_ctrl
    import seq_pkg::*;
(
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              jmp,
    input  logic              jmp_nz,
    input  logic              dont_jmp,
    input  logic [3:0]        jmp_addr,
    input  logic              call,
    input  logic              ret,
    input  logic              halt_req,
    input  logic              step_req,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              stack_ovf,
    output logic              stack_unf
);
    seq_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pm_addr, w_pc_inc, w_target;
    logic              r_halted;

    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_target = jmp_target(jmp_addr);
    assign pm_addr  = w_pm_addr;
    assign pc       = r_pc;
    assign halted   = r_halted;

`ifdef SEQ_CALL_STACK_EN
    logic              w_push, w_pop, w_full, w_empty, w_set_ovf, w_set_unf;
    logic              r_stack_ovf, r_stack_unf;
    logic [ADDR_W-1:0] w_top;

    seq_stack u_stack (
        .clk          (clk),
        .i_sync_reset (sync_reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_push_data  (w_pc_inc),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_top        (w_top)
    );

    assign stack_ovf = r_stack_ovf;
    assign stack_unf = r_stack_unf;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_stack_ovf <= 1'b0;
            r_stack_unf <= 1'b0;
        end else begin
            r_stack_ovf <= r_stack_ovf | w_set_ovf;
            r_stack_unf <= r_stack_unf | w_set_unf;
        end
    end
`else
    logic w_unused_callret;
    assign w_unused_callret = call ^ ret;
    assign stack_ovf        = 1'b0;
    assign stack_unf        = 1'b0;
`endif

    // Next-address priority chain; stack side effects only for the winning request.
    always_comb begin
        w_pm_addr = w_pc_inc;
`ifdef SEQ_CALL_STACK_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
`endif
        if (sync_reset)
            w_pm_addr = '0;
        else if (r_state == HALT)
            w_pm_addr = r_pc;
        else if (jmp)
            w_pm_addr = w_target;
        else if (jmp_nz && !dont_jmp)
            w_pm_addr = w_target;
`ifdef SEQ_CALL_STACK_EN
        else if (call) begin
            // Overflow still takes the jump; the return address is lost.
            w_pm_addr = w_target;
            if (w_full)
                w_set_ovf = 1'b1;
            else
                w_push = 1'b1;
        end else if (ret) begin
            if (w_empty)
                w_set_unf = 1'b1;
            else begin
                w_pop     = 1'b1;
                w_pm_addr = w_top;
            end
        end
`endif
    end

    // Debug FSM next state; STEP always lasts exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (halt_req) w_state_nxt = HALT;
            HALT:    if (step_req) w_state_nxt = STEP;
                     else if (!halt_req) w_state_nxt = RUN;
            STEP:    w_state_nxt = halt_req ? HALT : RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // PC, FSM state and registered halted flag.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_pc     <= '0;
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            r_pc     <= w_pm_addr;
            r_state  <= w_state_nxt;
            r_halted <= (w_state_nxt == HALT);
        end
    end
endmodule

// File: tb/tb_program_sequencer_ctrl.sv
// Directed bench for program_sequencer_ctrl; stack checks follow SEQ_CALL_STACK_EN.
module tb_program_sequencer_ctrl;
    logic       clk = 1'b0;
    logic       sync_reset, jmp, jmp_nz, dont_jmp, call, ret, halt_req, step_req;
    logic [3:0] jmp_addr;
    logic [7:0] pm_addr, pc;
    logic       halted, stack_ovf, stack_unf;
    int         n_chk = 0;
    int         n_err = 0;

    program_sequencer_ctrl dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .dont_jmp   (dont_jmp),
        .jmp_addr   (jmp_addr),
        .call       (call),
        .ret        (ret),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .pm_addr    (pm_addr),
        .pc         (pc),
        .halted     (halted),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic jump_to(input logic [3:0] nib);
        jmp = 1'b1; jmp_addr = nib;
        tick();
        jmp = 1'b0;
    endtask

    initial begin
        logic [7:0] pops [4];
        pops[0] = 8'h31; pops[1] = 8'h21; pops[2] = 8'h11; pops[3] = 8'h07;

        sync_reset = 1'b1; jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0;
        call = 1'b0; ret = 1'b0; halt_req = 1'b0; step_req = 1'b0; jmp_addr = 4'h0;
        tick(); tick();
        chk("rst_pm", pm_addr, 8'h00);
        chk("rst_pc", pc, 8'h00);
        chk("rst_halted", halted, 1'b0);
        chk("rst_ovf", stack_ovf, 1'b0);
        chk("rst_unf", stack_unf, 1'b0);

        // free run with wrap
        sync_reset = 1'b0;
        settle();
        for (int i = 0; i < 260; i++) begin
            chk("run_pm", pm_addr, (i + 1) & 8'hFF);
            tick();
        end
        chk("run_pc_wrap", pc, 8'h04);
        chk("run_ovf", stack_ovf, 1'b0);
        chk("run_unf", stack_unf, 1'b0);

        // jumps
        jump_to(4'h1);
        tick(); tick();
        chk("pc_12", pc, 8'h12);
        jmp = 1'b1; jmp_addr = 4'hA; settle();
        chk("jmp_pm", pm_addr, 8'hA0);
        tick(); jmp = 1'b0;
        chk("jmp_pc", pc, 8'hA0);
        jump_to(4'h3);
        jmp_nz = 1'b1; dont_jmp = 1'b1; jmp_addr = 4'h7; settle();
        chk("jnz_sup_pm", pm_addr, 8'h31);
        tick();
        chk("jnz_sup_pc", pc, 8'h31);
        dont_jmp = 1'b0; jmp_addr = 4'h5; settle();
        chk("jnz_take_pm", pm_addr, 8'h50);
        tick(); jmp_nz = 1'b0;
        chk("jnz_take_pc", pc, 8'h50);

        jump_to(4'h0);
        repeat (5) tick();
        chk("pc_05", pc, 8'h05);
`ifdef SEQ_CALL_STACK_EN
        call = 1'b1; jmp_addr = 4'h3; settle();
        chk("call_pm", pm_addr, 8'h30);
        tick(); call = 1'b0;
        ret = 1'b1; settle();
        chk("ret_pm", pm_addr, 8'h06);
        tick(); ret = 1'b0;
        chk("ret_pc", pc, 8'h06);
        for (int k = 1; k <= 5; k++) begin
            call = 1'b1; jmp_addr = 4'(k); settle();
            chk("nest_pm", pm_addr, k << 4);
            tick();
            chk("nest_ovf", stack_ovf, (k == 5) ? 1'b1 : 1'b0);
        end
        call = 1'b0;
        chk("ovf_pc", pc, 8'h50);
        for (int k = 0; k < 4; k++) begin
            ret = 1'b1; settle();
            chk("pop_pm", pm_addr, pops[k]);
            tick();
        end
        ret = 1'b0;
        // losing call must not push
        jmp = 1'b1; call = 1'b1; jmp_addr = 4'h4; settle();
        chk("jmp_call_pm", pm_addr, 8'h40);
        tick(); jmp = 1'b0; call = 1'b0;
        chk("jmp_call_unf", stack_unf, 1'b0);
        ret = 1'b1; settle();
        chk("unf_pm", pm_addr, 8'h41);
        tick(); ret = 1'b0;
        chk("unf_pc", pc, 8'h41);
        repeat (3) tick();
        chk("unf_sticky", stack_unf, 1'b1);
        chk("ovf_sticky", stack_ovf, 1'b1);
`else
        call = 1'b1; jmp_addr = 4'h3; settle();
        chk("nocall_pm", pm_addr, 8'h06);
        tick(); call = 1'b0;
        ret = 1'b1; settle();
        chk("noret_pm", pm_addr, 8'h07);
        tick(); ret = 1'b0;
        chk("noflag_ovf", stack_ovf, 1'b0);
        chk("noflag_unf", stack_unf, 1'b0);
`endif

        // halt / step
        jump_to(4'h2);
        halt_req = 1'b1; settle();
        chk("halt_pm", pm_addr, 8'h21);
        chk("halt_pre", halted, 1'b0);
        tick();
        chk("halt_pc", pc, 8'h21);
        chk("halted", halted, 1'b1);
        jmp = 1'b1; jmp_nz = 1'b1; call = 1'b1; ret = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("hold_pm", pm_addr, 8'h21);
            tick();
            chk("hold_pc", pc, 8'h21);
        end
        jmp = 1'b0; jmp_nz = 1'b0; call = 1'b0; ret = 1'b0;
        step_req = 1'b1;
        tick(); step_req = 1'b0;
        chk("step_halted", halted, 1'b0);
        chk("step_pm", pm_addr, 8'h22);
        tick();
        chk("step_pc", pc, 8'h22);
        chk("step_rehalt", halted, 1'b1);
        repeat (3) tick();
        chk("step_hold", pc, 8'h22);
        halt_req = 1'b0;
        tick();
        chk("resume_halted", halted, 1'b0);
        tick();
        chk("resume_pc", pc, 8'h23);
        step_req = 1'b1;
        tick(); step_req = 1'b0;
        chk("step_ign_pc", pc, 8'h24);
        chk("step_ign_halted", halted, 1'b0);

        // reset while halted with a pending call
        halt_req = 1'b1;
        tick();
        chk("halt2", halted, 1'b1);
        call = 1'b1; jmp_addr = 4'h9; sync_reset = 1'b1; settle();
        chk("rst_halt_pm", pm_addr, 8'h00);
        tick();
        sync_reset = 1'b0; call = 1'b0; halt_req = 1'b0; settle();
        chk("rst_halt_pc", pc, 8'h00);
        chk("rst_halt_halted", halted, 1'b0);
        chk("rst_halt_ovf", stack_ovf, 1'b0);
        chk("rst_halt_unf", stack_unf, 1'b0);
`ifdef SEQ_CALL_STACK_EN
        ret = 1'b1; settle();
        chk("rst_sp0_pm", pm_addr, 8'h01);
        tick(); ret = 1'b0;
        chk("rst_sp0_unf", stack_unf, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
